// File: rtl/rfphoenix_alu_result_queue.sv
// rfphoenix_alu_result_queue: in-order ALU result FIFO draining to a register-file write port with bypass lookup
module rfphoenix_alu_result_queue #(
  parameter int DEPTH = 4,
  parameter int RW = 6,
  parameter int WID = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic res_valid,
  output logic res_ready,
  input  logic [RW-1:0] res_tgt,
  input  logic [WID-1:0] res_val,
  output logic wb_valid,
  input  logic wb_ack,
  output logic [RW-1:0] wb_tgt,
  output logic [WID-1:0] wb_val,
  input  logic [RW-1:0] byp_reg,
  output logic byp_hit,
  output logic [WID-1:0] byp_val,
  output logic [$clog2(DEPTH):0] count,
  output logic err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [RW-1:0] tgt_q [DEPTH];
  logic [WID-1:0] val_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] rd_ptr, wr_ptr, idx;
  logic [AW:0] cnt;
  logic err_q, enq, deq;
  assign res_ready = !rst && cnt < FULL;
  assign wb_valid = !rst && cnt != '0;
  assign enq = res_valid && res_ready && res_tgt != '0;
  assign deq = wb_valid && wb_ack;
  assign wb_tgt = tgt_q[rd_ptr];
  assign wb_val = val_q[rd_ptr];
  assign count = cnt;
  assign err = err_q;
  // walk oldest to youngest so the youngest match is the one left standing
  always_comb begin
    byp_hit = 1'b0;
    byp_val = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (!rst && byp_reg != '0 && vld[idx] && tgt_q[idx] == byp_reg) begin
        byp_hit = 1'b1;
        byp_val = val_q[idx];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
      vld <= '0;
      err_q <= 1'b0;
    end else begin
      if (deq) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (enq) begin
        tgt_q[wr_ptr] <= res_tgt;
        val_q[wr_ptr] <= res_val;
        vld[wr_ptr] <= 1'b1;
        wr_ptr <= wr_ptr + AW'(1);
      end
      cnt <= cnt + (AW+1)'(enq) - (AW+1)'(deq);
      err_q <= err_q | (res_valid && !res_ready);
    end
  end
endmodule

// File: doc/rfphoenix_alu_result_queue.md
Name: rfphoenix_alu_result_queue

Overview:
- Consumer end of the ALU result interface: accepts one ALU result per cycle (value plus destination register) through a valid/ready handshake.
- Buffers results in a small in-order FIFO and drains them to a register-file write port through a valid/ack handshake.
- The register file may refuse writes, for example while load writeback has priority.
- Provides a combinational bypass lookup so issue logic can read results that are queued but not yet written.

Parameters:
- DEPTH, 4: number of FIFO entries; power of two, 2..16.
- RW, 6: register index width.
- WID, 32: result value width; matches the ALU output width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- res_valid  in  1  ALU result present this cycle.
- res_ready  out  1  queue can accept a result this cycle.
- res_tgt  in  RW  destination register of the result.
- res_val  in  WID  ALU result value (compare results are 0/1, zero-extended).
- wb_valid  out  1  head entry is presented to the register file.
- wb_ack  in  1  register file accepts the head write this cycle.
- wb_tgt  out  RW  head destination register.
- wb_val  out  WID  head value.
- byp_reg  in  RW  register index for the bypass lookup.
- byp_hit  out  1  a queued entry targets byp_reg.
- byp_val  out  WID  value of the youngest matching queued entry.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (clk edge with rst=1):
  - rd/wr pointers, count and err go to 0.
  - Entry valid bits clear; entry contents are don't-care.
  - While rst=1: res_ready=0, wb_valid=0, byp_hit=0.
  - Reset mid-operation discards all queued entries; no write is issued for them.
- Accept:
  - res_ready = !rst && count<DEPTH. It is combinational from registered state and never depends on wb_ack.
  - A transfer happens when res_valid && res_ready.
  - If res_tgt != 0: the entry is written at wr_ptr on that edge, wr_ptr increments modulo DEPTH, and the entry's valid bit sets.
  - If res_tgt == 0 (r0 is hardwired zero): the handshake completes but nothing is enqueued and count is unchanged.
- Drain:
  - wb_valid = (count != 0); wb_tgt and wb_val come from the entry at rd_ptr.
  - On an edge with wb_valid && wb_ack: the head's valid bit clears and rd_ptr increments modulo DEPTH.
  - wb_ack while wb_valid=0 is ignored.
  - wb_tgt and wb_val hold stable while wb_valid=1 and wb_ack=0.
- Latency:
  - A result accepted at edge N is visible on wb_* and bypass from edge N onward, i.e. in cycle N+1 at the earliest.
  - There is no same-cycle input-to-output path.
- Simultaneous accept and drain in one cycle: both occur and count is unchanged. This can happen only when count<DEPTH. When full, res_ready=0 even if wb_ack=1.
- count update: +1 on an enqueue only, -1 on a dequeue only, unchanged when both or neither occur. count never exceeds DEPTH or goes below 0.
- Bypass (combinational):
  - Scan valid entries from youngest (wr_ptr-1) to oldest (rd_ptr), wrapping modulo DEPTH.
  - byp_hit=1 and byp_val = value of the first entry whose tgt == byp_reg.
  - byp_reg==0 gives byp_hit=0.
  - With no match: byp_hit=0 and byp_val=0.
  - The head entry being dequeued in the current cycle still participates in the lookup that cycle.
  - The incoming res_* entry does not participate.
- err: set to 1 on any edge where res_valid=1 and res_ready=0 while rst=0. In that case the offered result is dropped and producer stall logic is broken. err stays set until reset.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are determined by count, not by pointer compare.

Test Plan:
- Reset, then idle: res_ready=1, wb_valid=0, count=0, err=0. Assert rst mid-fill with 3 entries queued -> after that edge count=0, wb_valid=0, no write issued.
- Enqueue (r5,0x11),(r6,0x22),(r5,0x33) with wb_ack=0 -> count=3, wb_tgt=5, wb_val=0x11 held stable. byp_reg=5 -> hit=1, val=0x33. byp_reg=7 -> hit=0, val=0.
- Fill to DEPTH=4 with wb_ack=0 -> res_ready=0. Offer res_valid=1 -> err=1 and count stays 4. Then wb_ack=1 for one cycle -> count=3 and res_ready=1 the next cycle.
- Enqueue (r0,0xFF) -> handshake completes, count unchanged, no write issued. byp_reg=0 -> hit=0.
- Continuous stream of 12 results with wb_ack=1 every cycle -> count stays at 1 after the first result, writes appear in order, each one cycle after acceptance, pointers wrap 3 times, no err.
- Random wb_ack backpressure (50%) over 200 results with ready-respecting producer -> write sequence equals accepted sequence minus r0 targets. Bypass always matches the youngest pending value per a reference model.
